// File: rtl/int_arb.sv
// Interrupt arbiter: picks the highest-level eligible source above cpu_ipl and runs the req/ack handshake.
// Optional build macro INT_PREEMPT_EN: a strictly higher-level source may replace the winner while in REQ.
module int_arb #(
   parameter int unsigned          NUM_SRC    = 4,
   parameter logic [3*NUM_SRC-1:0] SRC_LEVELS = 12'b100_101_100_110,
   parameter int unsigned          WAIT_MAX   = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SRC-1:0]     irq,
   input  logic [8*NUM_SRC-1:0]   vec,
   input  logic [2:0]             cpu_ipl,
   input  logic                   int_ack,
   output logic                   int_req,
   output logic [7:0]             int_vector,
   output logic [NUM_SRC-1:0]     ack_src,
   output logic                   stuck_err
);

   localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned CW = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t               state_q;
   logic [IW-1:0]        win_q;
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_d;
   logic                 req_q;
   logic [7:0]           vec_q;
   logic [NUM_SRC-1:0]   ack_q;
   logic                 stuck_q;

   logic [IW-1:0]        best_idx;
   logic [2:0]           best_lvl;
   logic                 any_elig;
   logic [7:0]           best_vec;
   logic [2:0]           win_lvl;
   logic                 win_irq;

   // Strict '>' on best_lvl keeps the lowest index on equal levels.
   always_comb begin
      best_idx = '0;
      best_lvl = '0;
      any_elig = 1'b0;
      win_lvl  = '0;
      win_irq  = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (irq[i] && (SRC_LEVELS[3*i +: 3] > cpu_ipl) && (SRC_LEVELS[3*i +: 3] > best_lvl)) begin
            best_idx = IW'(i);
            best_lvl = SRC_LEVELS[3*i +: 3];
            any_elig = 1'b1;
         end
         if (win_q == IW'(i)) begin
            win_lvl = SRC_LEVELS[3*i +: 3];
            win_irq = irq[i];
         end
      end
      best_vec = vec[8*best_idx +: 8];
      cnt_d    = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         vec_q   <= '0;
         ack_q   <= '0;
         stuck_q <= 1'b0;
      end else begin
         ack_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (any_elig) begin
                  win_q   <= best_idx;
                  vec_q   <= best_vec;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (int_ack) begin
                  req_q   <= 1'b0;
                  ack_q   <= {{(NUM_SRC-1){1'b0}}, 1'b1} << win_q;
                  cnt_q   <= '0;
                  state_q <= S_WAIT;
               end
`ifdef INT_PREEMPT_EN
               else if (any_elig && (best_lvl > win_lvl)) begin
                  win_q <= best_idx;
                  vec_q <= best_vec;
               end
`endif
               else if (!win_irq || (win_lvl <= cpu_ipl)) begin
                  req_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_WAIT: begin
               // Hold off re-arbitration until the acknowledged source drops irq.
               if (!win_irq) begin
                  state_q <= S_IDLE;
               end else if (cnt_d == CW'(WAIT_MAX)) begin
                  stuck_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign int_req    = req_q;
   assign int_vector = vec_q;
   assign ack_src    = ack_q;
   assign stuck_err  = stuck_q;

endmodule
